multicycle_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the 16-bit processor datapath. Steps each instruction through FETCH/DECODE/EXEC/MEM/WB states. Handshakes with instruction and data memory and gates the decoder's write enables so that register-file and data-memory writes occur only in the correct cycle. Sits between the combinational instruction decoder, the PC/IR registers and the memories.

---
 rtl/multicycle_sequencer_pkg.sv | 52 +++++
 rtl/multicycle_sequencer_perf_cnt.sv | 26 ++
 rtl/multicycle_sequencer.sv | 133 +++++++++++++
 tb/tb_multicycle_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encodings, opcode map
// and the opcode classifier used in EXEC and WB.
package multicycle_sequencer_pkg;

   localparam int STATE_W  = 3;
   localparam int OPCODE_W = 6;
   localparam int WAIT_W   = 8;

   typedef enum logic [STATE_W-1:0] {
      SEQ_IDLE   = 3'd0,
      SEQ_FETCH  = 3'd1,
      SEQ_DECODE = 3'd2,
      SEQ_EXEC   = 3'd3,
      SEQ_MEM    = 3'd4,
      SEQ_WB     = 3'd5,
      SEQ_ERR    = 3'd6
   } seq_state_e;

   localparam logic [OPCODE_W-1:0] OPCODE_ADD  = 6'h00;
   localparam logic [OPCODE_W-1:0] OPCODE_SUB  = 6'h01;
   localparam logic [OPCODE_W-1:0] OPCODE_AND  = 6'h02;
   localparam logic [OPCODE_W-1:0] OPCODE_OR   = 6'h03;
   localparam logic [OPCODE_W-1:0] OPCODE_SLT  = 6'h04;
   localparam logic [OPCODE_W-1:0] OPCODE_ADDI = 6'h08;
   localparam logic [OPCODE_W-1:0] OPCODE_ANDI = 6'h09;
   localparam logic [OPCODE_W-1:0] OPCODE_ORI  = 6'h0A;
   localparam logic [OPCODE_W-1:0] OPCODE_LW   = 6'h10;
   localparam logic [OPCODE_W-1:0] OPCODE_SW   = 6'h11;
   localparam logic [OPCODE_W-1:0] OPCODE_BEQ  = 6'h18;
   localparam logic [OPCODE_W-1:0] OPCODE_BNE  = 6'h19;
   localparam logic [OPCODE_W-1:0] OPCODE_J    = 6'h1A;

   typedef enum logic [1:0] {
      OP_CLS_ALU,
      OP_CLS_MEM,
      OP_CLS_BRANCH,
      OP_CLS_UNDEF
   } op_class_e;

   function automatic op_class_e classify_opcode(input logic [OPCODE_W-1:0] opcode);
      op_class_e cls;
      case (opcode)
         OPCODE_ADD, OPCODE_SUB, OPCODE_AND, OPCODE_OR, OPCODE_SLT,
         OPCODE_ADDI, OPCODE_ANDI, OPCODE_ORI: cls = OP_CLS_ALU;
         OPCODE_LW, OPCODE_SW:                 cls = OP_CLS_MEM;
         OPCODE_BEQ, OPCODE_BNE, OPCODE_J:     cls = OP_CLS_BRANCH;
         default:                              cls = OP_CLS_UNDEF;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/multicycle_sequencer_perf_cnt.sv
// Busy-cycle and retired-instruction counters, wrapping modulo 2^CNT_W.
// Compiled only when SEQ_PERF_CNT_EN is defined.
`ifdef SEQ_PERF_CNT_EN
module seq_perf_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cycle_en,
   input  logic             instr_en,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt
);

   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         if (cycle_en) cycle_cnt <= cycle_cnt + CNT_W'(1);
         if (instr_en) instr_cnt <= instr_cnt + CNT_W'(1);
      end
   end

endmodule
`endif

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer gating decoder write enables.
// Optional SEQ_PERF_CNT_EN adds cycle_cnt/instr_cnt outputs.
module multicycle_sequencer
   import multicycle_sequencer_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
`ifdef SEQ_PERF_CNT_EN
   ,
   parameter int CNT_W = 32
`endif
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   input  logic [15:0]        im_out,
   input  logic               im_ready,
   input  logic               dm_ready,
   input  logic               wrf_dec,
   input  logic               wdm_dec,
   input  logic               ld_dec,
   output logic               im_req,
   output logic               ir_we,
   output logic               pc_we,
   output logic               dm_req,
   output logic               wrf,
   output logic               wdm,
   output logic [STATE_W-1:0] state,
   output logic               busy,
   output logic               err
`ifdef SEQ_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]   cycle_cnt,
   output logic [CNT_W-1:0]   instr_cnt
`endif
);

   // Last waiting cycle: a ready here still wins, its absence goes to ERR.
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);

   seq_state_e        cur_state;
   seq_state_e        retire_state;
   logic [WAIT_W-1:0] wait_cnt;
   op_class_e         op_class;
   logic              unused_operand;

   assign op_class       = classify_opcode(im_out[15:10]);
   assign retire_state   = run ? SEQ_FETCH : SEQ_IDLE;
   assign unused_operand = ^im_out[9:0];

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_state <= SEQ_IDLE;
         wait_cnt  <= '0;
      end else begin
         wait_cnt <= '0;
         case (cur_state)
            SEQ_IDLE: begin
               if (run) cur_state <= SEQ_FETCH;
            end
            SEQ_FETCH: begin
               if (im_ready)                   cur_state <= SEQ_DECODE;
               else if (wait_cnt == WAIT_LIMIT) cur_state <= SEQ_ERR;
               else                            wait_cnt  <= wait_cnt + WAIT_W'(1);
            end
            SEQ_DECODE: cur_state <= SEQ_EXEC;
            SEQ_EXEC: begin
               case (op_class)
                  OP_CLS_BRANCH: cur_state <= retire_state;
                  OP_CLS_MEM:    cur_state <= SEQ_MEM;
                  default:       cur_state <= SEQ_WB;
               endcase
            end
            SEQ_MEM: begin
               if (dm_ready)                   cur_state <= ld_dec ? SEQ_WB : retire_state;
               else if (wait_cnt == WAIT_LIMIT) cur_state <= SEQ_ERR;
               else                            wait_cnt  <= wait_cnt + WAIT_W'(1);
            end
            SEQ_WB:  cur_state <= retire_state;
            SEQ_ERR: cur_state <= SEQ_ERR;
            default: cur_state <= SEQ_IDLE;
         endcase
      end
   end

   // NOTE: every output gets a default first, so no path can infer a latch.
   always_comb begin
      im_req = 1'b0;
      ir_we  = 1'b0;
      pc_we  = 1'b0;
      dm_req = 1'b0;
      wrf    = 1'b0;
      wdm    = 1'b0;
      if (!rst) begin
         case (cur_state)
            SEQ_FETCH: begin
               im_req = 1'b1;
               ir_we  = im_ready;
            end
            SEQ_EXEC: pc_we = (op_class == OP_CLS_BRANCH);
            SEQ_MEM: begin
               dm_req = 1'b1;
               wdm    = wdm_dec;
               pc_we  = dm_ready & ~ld_dec;
            end
            SEQ_WB: begin
               // The IR still holds the instruction, so undefined opcodes are re-detected here.
               wrf   = wrf_dec & (op_class != OP_CLS_UNDEF);
               pc_we = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign state = cur_state;
   assign busy  = (cur_state != SEQ_IDLE) && (cur_state != SEQ_ERR);
   assign err   = (cur_state == SEQ_ERR);

`ifdef SEQ_PERF_CNT_EN
   seq_perf_cnt #(
      .CNT_W (CNT_W)
   ) u_perf_cnt (
      .clk       (clk),
      .rst       (rst),
      .cycle_en  (busy),
      .instr_en  (pc_we),
      .cycle_cnt (cycle_cnt),
      .instr_cnt (instr_cnt)
   );
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: a per-cycle vector table plus
// hand-written timeout/reset sequences; perf counters checked under SEQ_PERF_CNT_EN.
module tb_multicycle_sequencer;
   import multicycle_sequencer_pkg::*;

   localparam logic [5:0] S_0  = 6'b000000;
   localparam logic [5:0] S_IM = 6'b100000;
   localparam logic [5:0] S_IR = 6'b010000;
   localparam logic [5:0] S_PC = 6'b001000;
   localparam logic [5:0] S_DM = 6'b000100;
   localparam logic [5:0] S_RF = 6'b000010;
   localparam logic [5:0] S_WM = 6'b000001;
   localparam logic [5:0] OP_UNDEF = 6'h3F;

   logic        clk = 1'b0;
   logic        rst, run, im_ready, dm_ready, wrf_dec, wdm_dec, ld_dec;
   logic [15:0] im_out;
   logic        im_req, ir_we, pc_we, dm_req, wrf, wdm, busy, err;
   logic [2:0]  state;
`ifdef SEQ_PERF_CNT_EN
   logic [3:0]  cycle_cnt, instr_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   multicycle_sequencer #(
      .MEM_TIMEOUT (15)
`ifdef SEQ_PERF_CNT_EN
      , .CNT_W (4)
`endif
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .im_out   (im_out),
      .im_ready (im_ready),
      .dm_ready (dm_ready),
      .wrf_dec  (wrf_dec),
      .wdm_dec  (wdm_dec),
      .ld_dec   (ld_dec),
      .im_req   (im_req),
      .ir_we    (ir_we),
      .pc_we    (pc_we),
      .dm_req   (dm_req),
      .wrf      (wrf),
      .wdm      (wdm),
      .state    (state),
      .busy     (busy),
      .err      (err)
`ifdef SEQ_PERF_CNT_EN
      ,
      .cycle_cnt (cycle_cnt),
      .instr_cnt (instr_cnt)
`endif
   );

   typedef struct {
      logic       run;
      logic [5:0] op;
      logic       imr, dmr, wd, wm, ld;
      logic [2:0] st;
      logic [5:0] strb;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(input logic rn, input logic [5:0] op, input logic imr,
                              input logic dmr, input logic wd, input logic wm,
                              input logic ld, input logic [2:0] st, input logic [5:0] strb);
      vec_t r;
      r.run = rn; r.op = op; r.imr = imr; r.dmr = dmr;
      r.wd = wd; r.wm = wm; r.ld = ld; r.st = st; r.strb = strb;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, required %0h", name, got, exp);
      end
   endtask

   // Drives one cycle's inputs at the falling edge and settles before sampling.
   task automatic step(input logic r, input logic rn, input logic [5:0] op, input logic imr,
                       input logic dmr, input logic wd, input logic wm, input logic ld);
      @(negedge clk);
      rst = r; run = rn; im_out = {op, 10'h155};
      im_ready = imr; dm_ready = dmr; wrf_dec = wd; wdm_dec = wm; ld_dec = ld;
      #1;
   endtask

   task automatic expect_cycle(input string name, input logic [2:0] st, input logic [5:0] strb);
      logic exp_busy, exp_err;
      exp_busy = (st != 3'd0) && (st != 3'd6);
      exp_err  = (st == 3'd6);
      check({name, ".state"}, 32'(state), 32'(st));
      check({name, ".out"}, 32'({im_req, ir_we, pc_we, dm_req, wrf, wdm, busy, err}),
            32'({strb, exp_busy, exp_err}));
   endtask

   // From IDLE, walks one memory instruction up to (not into) its first MEM cycle.
   task automatic enter_mem(input string tag, input logic [5:0] op, input logic wd,
                            input logic wm, input logic ld);
      step(0, 1, op, 1, 0, wd, wm, ld); expect_cycle({tag, ".idle"}, 3'd0, S_0);
      step(0, 0, op, 1, 0, wd, wm, ld); expect_cycle({tag, ".fetch"}, 3'd1, S_IM | S_IR);
      step(0, 0, op, 1, 0, wd, wm, ld); expect_cycle({tag, ".decode"}, 3'd2, S_0);
      step(0, 0, op, 1, 0, wd, wm, ld); expect_cycle({tag, ".exec"}, 3'd3, S_0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      // ADDI, zero-wait memories
      vecs.push_back(v(1, OPCODE_ADDI, 1, 1, 1, 0, 0, 3'd0, S_0));
      vecs.push_back(v(1, OPCODE_ADDI, 1, 1, 1, 0, 0, 3'd1, S_IM | S_IR));
      vecs.push_back(v(1, OPCODE_ADDI, 1, 1, 1, 0, 0, 3'd2, S_0));
      vecs.push_back(v(1, OPCODE_ADDI, 1, 1, 1, 0, 0, 3'd3, S_0));
      vecs.push_back(v(1, OPCODE_ADDI, 1, 1, 1, 0, 0, 3'd5, S_RF | S_PC));
      // LW, dm_ready delayed 3 cycles: 8 cycles total
      vecs.push_back(v(1, OPCODE_LW, 1, 0, 1, 0, 1, 3'd1, S_IM | S_IR));
      vecs.push_back(v(1, OPCODE_LW, 1, 0, 1, 0, 1, 3'd2, S_0));
      vecs.push_back(v(1, OPCODE_LW, 1, 0, 1, 0, 1, 3'd3, S_0));
      vecs.push_back(v(1, OPCODE_LW, 1, 0, 1, 0, 1, 3'd4, S_DM));
      vecs.push_back(v(1, OPCODE_LW, 1, 0, 1, 0, 1, 3'd4, S_DM));
      vecs.push_back(v(1, OPCODE_LW, 1, 0, 1, 0, 1, 3'd4, S_DM));
      vecs.push_back(v(1, OPCODE_LW, 1, 1, 1, 0, 1, 3'd4, S_DM));
      vecs.push_back(v(1, OPCODE_LW, 1, 1, 1, 0, 1, 3'd5, S_RF | S_PC));
      // SW with one fetch wait and one data wait
      vecs.push_back(v(1, OPCODE_SW, 0, 0, 0, 1, 0, 3'd1, S_IM));
      vecs.push_back(v(1, OPCODE_SW, 1, 0, 0, 1, 0, 3'd1, S_IM | S_IR));
      vecs.push_back(v(1, OPCODE_SW, 1, 0, 0, 1, 0, 3'd2, S_0));
      vecs.push_back(v(1, OPCODE_SW, 1, 0, 0, 1, 0, 3'd3, S_0));
      vecs.push_back(v(1, OPCODE_SW, 1, 0, 0, 1, 0, 3'd4, S_DM | S_WM));
      vecs.push_back(v(1, OPCODE_SW, 1, 1, 0, 1, 0, 3'd4, S_DM | S_WM | S_PC));
      // BEQ then J, run dropped in J's EXEC
      vecs.push_back(v(1, OPCODE_BEQ, 1, 1, 0, 0, 0, 3'd1, S_IM | S_IR));
      vecs.push_back(v(1, OPCODE_BEQ, 1, 1, 0, 0, 0, 3'd2, S_0));
      vecs.push_back(v(1, OPCODE_BEQ, 1, 1, 0, 0, 0, 3'd3, S_PC));
      vecs.push_back(v(1, OPCODE_J, 1, 1, 0, 0, 0, 3'd1, S_IM | S_IR));
      vecs.push_back(v(1, OPCODE_J, 1, 1, 0, 0, 0, 3'd2, S_0));
      vecs.push_back(v(0, OPCODE_J, 1, 1, 0, 0, 0, 3'd3, S_PC));
      // ADD with run dropped in WB
      vecs.push_back(v(1, OPCODE_ADD, 1, 1, 1, 0, 0, 3'd0, S_0));
      vecs.push_back(v(1, OPCODE_ADD, 1, 1, 1, 0, 0, 3'd1, S_IM | S_IR));
      vecs.push_back(v(1, OPCODE_ADD, 1, 1, 1, 0, 0, 3'd2, S_0));
      vecs.push_back(v(1, OPCODE_ADD, 1, 1, 1, 0, 0, 3'd3, S_0));
      vecs.push_back(v(0, OPCODE_ADD, 1, 1, 1, 0, 0, 3'd5, S_RF | S_PC));
      vecs.push_back(v(0, OPCODE_ADD, 1, 1, 1, 0, 0, 3'd0, S_0));
      // Undefined opcode: WB asserts pc_we only
      vecs.push_back(v(1, OP_UNDEF, 1, 1, 1, 0, 0, 3'd0, S_0));
      vecs.push_back(v(1, OP_UNDEF, 1, 1, 1, 0, 0, 3'd1, S_IM | S_IR));
      vecs.push_back(v(1, OP_UNDEF, 1, 1, 1, 0, 0, 3'd2, S_0));
      vecs.push_back(v(1, OP_UNDEF, 1, 1, 1, 0, 0, 3'd3, S_0));
      vecs.push_back(v(0, OP_UNDEF, 1, 1, 1, 0, 0, 3'd5, S_PC));
      vecs.push_back(v(0, OP_UNDEF, 1, 1, 1, 0, 0, 3'd0, S_0));

      rst = 1'b1; run = 1'b0; im_out = '0;
      im_ready = 1'b0; dm_ready = 1'b0; wrf_dec = 1'b0; wdm_dec = 1'b0; ld_dec = 1'b0;

      // Reset
      step(1, 1, OPCODE_ADD, 1, 1, 1, 1, 0);
      step(1, 1, OPCODE_ADD, 1, 1, 1, 1, 0);
      check("reset.strobes", 32'({im_req, ir_we, pc_we, dm_req, wrf, wdm}), 32'(S_0));
      step(0, 0, OPCODE_ADD, 1, 1, 1, 1, 0);
      expect_cycle("reset", 3'd0, S_0);

      foreach (vecs[i]) begin
         step(0, vecs[i].run, vecs[i].op, vecs[i].imr, vecs[i].dmr,
              vecs[i].wd, vecs[i].wm, vecs[i].ld);
         expect_cycle($sformatf("vec%0d", i), vecs[i].st, vecs[i].strb);
      end

      // Reset while in MEM with wdm_dec=1
      enter_mem("rstmem", OPCODE_SW, 0, 1, 0);
      step(0, 0, OPCODE_SW, 1, 0, 0, 1, 0); expect_cycle("rstmem.mem", 3'd4, S_DM | S_WM);
      step(1, 1, OPCODE_SW, 1, 0, 0, 1, 0); expect_cycle("rstmem.rst", 3'd4, S_0);
      step(0, 0, OPCODE_SW, 1, 0, 0, 1, 0); expect_cycle("rstmem.after", 3'd0, S_0);

      // dm_ready on the 15th MEM cycle: retires without ERR
      enter_mem("late", OPCODE_SW, 0, 1, 0);
      for (int i = 1; i <= 14; i++) begin
         step(0, 0, OPCODE_SW, 1, 0, 0, 1, 0);
         expect_cycle($sformatf("late.wait%0d", i), 3'd4, S_DM | S_WM);
      end
      step(0, 0, OPCODE_SW, 1, 1, 0, 1, 0); expect_cycle("late.ready", 3'd4, S_DM | S_WM | S_PC);
      step(0, 0, OPCODE_SW, 1, 1, 0, 1, 0); expect_cycle("late.retired", 3'd0, S_0);

      // MEM timeout on LW
      enter_mem("memto", OPCODE_LW, 1, 0, 1);
      for (int i = 1; i <= 15; i++) begin
         step(0, 0, OPCODE_LW, 1, 0, 1, 0, 1);
         expect_cycle($sformatf("memto.wait%0d", i), 3'd4, S_DM);
      end
      step(0, 0, OPCODE_LW, 1, 1, 1, 0, 1); expect_cycle("memto.err", 3'd6, S_0);
      step(1, 0, OPCODE_LW, 1, 1, 1, 0, 1); expect_cycle("memto.rst", 3'd6, S_0);
      step(0, 0, OPCODE_LW, 1, 1, 1, 0, 1); expect_cycle("memto.idle", 3'd0, S_0);

      // FETCH timeout, sticky ERR, reset recovery
      step(0, 1, OPCODE_ADD, 0, 0, 1, 0, 0); expect_cycle("imto.idle", 3'd0, S_0);
      for (int i = 1; i <= 15; i++) begin
         step(0, 1, OPCODE_ADD, 0, 0, 1, 0, 0);
         expect_cycle($sformatf("imto.fetch%0d", i), 3'd1, S_IM);
      end
      for (int i = 0; i < 4; i++) begin
         step(0, 1, OPCODE_ADD, 1, 1, 1, 1, 0);
         expect_cycle($sformatf("imto.err%0d", i), 3'd6, S_0);
      end
      step(1, 1, OPCODE_ADD, 1, 1, 1, 1, 0); expect_cycle("imto.rst", 3'd6, S_0);
      step(0, 0, OPCODE_ADD, 1, 1, 1, 1, 0); expect_cycle("imto.idle_after", 3'd0, S_0);

`ifdef SEQ_PERF_CNT_EN
      // 20 ALU instructions: 80 busy cycles, 20 retirements, 4-bit counters
      step(1, 0, OPCODE_ADDI, 1, 1, 1, 0, 0);
      step(0, 1, OPCODE_ADDI, 1, 1, 1, 0, 0);
      for (int i = 1; i <= 80; i++) step(0, (i != 80), OPCODE_ADDI, 1, 1, 1, 0, 0);
      step(0, 0, OPCODE_ADDI, 1, 1, 1, 0, 0);
      expect_cycle("perf.idle", 3'd0, S_0);
      check("perf.instr_cnt", 32'(instr_cnt), 32'd4);
      check("perf.cycle_cnt", 32'(cycle_cnt), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
